// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and helpers for the sequential ALU with BCD path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SCR_OP     = 2'd0,
        SCR_A      = 2'd1,
        SCR_B      = 2'd2,
        SCR_RESULT = 2'd3
    } scr_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // ceil(bits * log10(2)); log10(2) ~ 0.30103 and the product is never integral
    function automatic int bcd_digits(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// Module      : bcd_dabble_seq
// Description : Sequential double-dabble converter, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_seq #(
    parameter int BITS = 8,
    parameter int NDIG = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BITS-1:0]     din,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(BITS - 1);

    logic [4*NDIG-1:0] r_dig;
    logic [4*NDIG-1:0] w_adj;
    logic [BITS-1:0]   r_bin;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;

    genvar gi;
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_dig[4*gi +: 4] >= 4'd5) ? r_dig[4*gi +: 4] + 4'd3
                                                             : r_dig[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_dig  <= '0;
                r_bin  <= din;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_dig <= {w_adj[4*NDIG-2:0], r_bin[BITS-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == C_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_dig;

endmodule

`default_nettype wire

// File: rtl/seq_alu_bcd.sv
// ============================================================================
// Module      : seq_alu_bcd
// Description : Handshaked ALU (add/sub/mul/and/or/xor) with BCD display path.
//               ALU_COMB_MUL_EN selects a single-cycle multiplier array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_bcd
    import alu_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int NDIG  = bcd_digits(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 carry_in,
    input  logic [1:0]           screen,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [4*NDIG-1:0]    bcd,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 error
);

    localparam int RW = 2 * WIDTH;
    localparam int MSB = WIDTH - 1;

    state_e           r_state;
    op_e              r_op;
    scr_e             r_scr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [RW-1:0]    r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_err;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [RW-1:0]    w_mul;
    logic [RW-1:0]    w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_err;
    logic [RW-1:0]    w_disp;
    logic             w_exec_last;
    logic             w_dab_start;
    logic             w_dab_done;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};

`ifdef ALU_COMB_MUL_EN
    assign w_mul       = RW'(r_a) * RW'(r_b);
    assign w_exec_last = 1'b1;
`else
    localparam int MCW = $clog2(WIDTH + 1);
    localparam logic [MCW-1:0] C_MUL_LAST = MCW'(WIDTH - 1);

    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [MCW-1:0]   r_mcnt;

    // one partial product per EXEC cycle; w_mul is the running sum including this cycle's term
    assign w_mul       = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_exec_last = (r_op != OP_MUL) || (r_mcnt == C_MUL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mcnt   <= '0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_acc    <= '0;
            r_mcand  <= RW'(a);
            r_mplier <= b;
            r_mcnt   <= '0;
        end else if (r_state == ST_EXEC) begin
            r_acc    <= w_mul;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_mcnt   <= r_mcnt + MCW'(1);
        end
    end
`endif

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        w_err  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res  = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                w_cout = w_sum[WIDTH];
                w_ovf  = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_res  = {{WIDTH{1'b0}}, w_dif[WIDTH-1:0]};
                w_cout = w_dif[WIDTH];
                w_ovf  = (r_a[MSB] != r_b[MSB]) && (w_dif[MSB] != r_a[MSB]);
            end
            OP_MUL:  w_res = w_mul;
            OP_AND:  w_res = {{WIDTH{1'b0}}, r_a & r_b};
            OP_OR:   w_res = {{WIDTH{1'b0}}, r_a | r_b};
            OP_XOR:  w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_disp = '0;
        case (r_scr)
            SCR_OP:     w_disp = {{(RW-3){1'b0}}, r_op};
            SCR_A:      w_disp = {{WIDTH{1'b0}}, r_a};
            SCR_B:      w_disp = {{WIDTH{1'b0}}, r_b};
            SCR_RESULT: w_disp = w_res;
            default:    w_disp = '0;
        endcase
    end

    assign w_dab_start = (r_state == ST_EXEC) && w_exec_last;

    bcd_dabble_seq #(
        .BITS (RW),
        .NDIG (NDIG)
    ) u_dabble (
        .clk   (clk),
        .rst   (rst),
        .start (w_dab_start),
        .din   (w_disp),
        .done  (w_dab_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_scr    <= SCR_OP;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_op    <= op_e'(opcode);
                    r_scr   <= scr_e'(screen);
                    r_a     <= a;
                    r_b     <= b;
                    r_cin   <= carry_in;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: if (w_exec_last) begin
                    r_result <= w_res;
                    r_cout   <= w_cout;
                    r_ovf    <= w_ovf;
                    r_err    <= w_err;
                    r_state  <= ST_CONV;
                end
                ST_CONV: if (w_dab_done) r_state <= ST_DONE;
                ST_DONE: if (out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign error     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu_bcd.sv
// ============================================================================
// Module      : tb_seq_alu_bcd
// Description : Directed self-checking bench for seq_alu_bcd (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu_bcd;

`ifdef ALU_COMB_MUL_EN
    localparam int MUL_LAT = 10;
`else
    localparam int MUL_LAT = 13;
`endif
    localparam int OP_LAT = 10;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        carry_in;
    logic [1:0]  screen;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic [11:0] bcd;
    logic        carry_out;
    logic        overflow;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu_bcd #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .screen    (screen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bcd       (bcd),
        .carry_out (carry_out),
        .overflow  (overflow),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] ai,
                          input logic [3:0] bi, input logic ci, input logic [1:0] sc,
                          input int lat, input logic [7:0] eres, input logic [11:0] ebcd,
                          input logic ecout, input logic eovf, input logic eerr, input int hold);
        int n;
        n = 0;
        opcode = op; a = ai; b = bi; carry_in = ci; screen = sc;
        in_valid = 1'b1; out_ready = 1'b0;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // scramble inputs and keep requesting: both must be ignored while busy
        opcode = ~op; a = ~ai; b = bi + 4'd1; carry_in = ~ci; screen = sc + 2'd1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_result"}, 32'(result), 32'(eres));
        check({name, "_bcd"}, 32'(bcd), 32'(ebcd));
        check({name, "_cout"}, 32'(carry_out), 32'(ecout));
        check({name, "_ovf"}, 32'(overflow), 32'(eovf));
        check({name, "_err"}, 32'(error), 32'(eerr));
        check({name, "_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_result"}, 32'(result), 32'(eres));
            check({name, "_hold_bcd"}, 32'(bcd), 32'(ebcd));
            check({name, "_hold_flags"}, {29'd0, carry_out, overflow, error},
                  {29'd0, ecout, eovf, eerr});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_ready"}, 32'(in_ready), 32'd1);
        check({name, "_post_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a = '0; b = '0; carry_in = 1'b0; screen = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_flags", {29'd0, carry_out, overflow, error}, 32'd0);

        //      name      op    a     b     ci    scr  lat      res    bcd      co    ov    er   hold
        run_op("add",     3'd0, 4'd9, 4'd8, 1'b1, 2'd3, OP_LAT,  8'd2,   12'h002, 1'b1, 1'b1, 1'b0, 0);
        run_op("mul",     3'd2, 4'hF, 4'hF, 1'b0, 2'd3, MUL_LAT, 8'd225, 12'h225, 1'b0, 1'b0, 1'b0, 0);
        run_op("mul_b1",  3'd2, 4'd6, 4'd7, 1'b1, 2'd3, MUL_LAT, 8'd42,  12'h042, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub",     3'd1, 4'd3, 4'd5, 1'b0, 2'd3, OP_LAT,  8'd14,  12'h014, 1'b1, 1'b0, 1'b0, 0);
        run_op("sub_scrb",3'd1, 4'd3, 4'd5, 1'b0, 2'd2, OP_LAT,  8'd14,  12'h005, 1'b1, 1'b0, 1'b0, 0);
        run_op("sub_ovf", 3'd1, 4'd8, 4'd1, 1'b0, 2'd3, OP_LAT,  8'd7,   12'h007, 1'b0, 1'b1, 1'b0, 0);
        run_op("ill6",    3'd6, 4'd5, 4'd5, 1'b1, 2'd3, OP_LAT,  8'd0,   12'h000, 1'b0, 1'b0, 1'b1, 0);
        run_op("and_hold",3'd3, 4'hC, 4'hA, 1'b0, 2'd3, OP_LAT,  8'd8,   12'h008, 1'b0, 1'b0, 1'b0, 5);
        run_op("or_scra", 3'd4, 4'hC, 4'hA, 1'b0, 2'd1, OP_LAT,  8'd14,  12'h012, 1'b0, 1'b0, 1'b0, 0);
        run_op("or_scrop",3'd4, 4'h1, 4'h2, 1'b0, 2'd0, OP_LAT,  8'd3,   12'h004, 1'b0, 1'b0, 1'b0, 0);
        run_op("add_max", 3'd0, 4'hF, 4'hF, 1'b1, 2'd3, OP_LAT,  8'd15,  12'h015, 1'b1, 1'b0, 1'b0, 0);
        run_op("add_pov", 3'd0, 4'd7, 4'd1, 1'b0, 2'd3, OP_LAT,  8'd8,   12'h008, 1'b0, 1'b1, 1'b0, 0);

        // reset in the middle of a conversion discards the operation
        opcode = 3'd0; a = 4'd9; b = 4'd8; carry_in = 1'b1; screen = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_bcd", 32'(bcd), 32'd0);
        check("rstmid_flags", {29'd0, carry_out, overflow, error}, 32'd0);
        run_op("xor",     3'd5, 4'hA, 4'h6, 1'b0, 2'd3, OP_LAT,  8'd12,  12'h012, 1'b0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu_bcd.md
# seq_alu_bcd

Parametrised, clocked successor to the combinational 4-bit ALU with BCD display path. It accepts one operation per valid/ready handshake and executes add, subtract, multiply, AND, OR or XOR on WIDTH-bit operands. The selected display value is converted to BCD digits with a sequential double-dabble engine. Results, flags and digits are held until the consumer accepts them. It sits between the operand/opcode switch logic and the seven-segment display driver.

## Interface
- WIDTH, 4: operand width in bits, 2 to 16.
- NDIG, alu_pkg::bcd_digits(2*WIDTH): BCD digit count, derived and not overridden (3 for WIDTH=4).
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous and active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- opcode  in  3  0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6/7 illegal.
- a, b  in  WIDTH  operands, unsigned.
- carry_in  in  1  carry for add, borrow for sub; ignored otherwise.
- screen  in  2  display select: 0 opcode, 1 a, 2 b, 3 result.
- out_valid  out  1  result, flags and digits valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  operation result, zero-extended (full product for mul).
- bcd  out  4*NDIG  display digits, most significant digit in the top nibble.
- carry_out  out  1  add carry-out or sub borrow-out; 0 for other opcodes.
- overflow  out  1  two's-complement overflow for add/sub; 0 for other opcodes.
- error  out  1  illegal opcode.

## Operation
- FSM states and transitions:
  - IDLE -> EXEC on the in_valid && in_ready edge.
  - EXEC -> CONV when the arithmetic completes.
  - CONV -> DONE after 2*WIDTH shift steps.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Operand capture: opcode, a, b, carry_in and screen are all registered at acceptance. Later changes on these inputs are ignored.
- Add: {carry_out, result[WIDTH-1:0]} = a + b + carry_in.
- Sub: result[WIDTH-1:0] = a - b - carry_in (mod 2^WIDTH). carry_out = 1 when the true difference is below 0.
- Add/sub result[2*WIDTH-1:WIDTH] = 0. overflow follows signed interpretation of a, b and the WIDTH-bit result.
- Mul: result = a * b, unsigned, full 2*WIDTH bits.
- Logic ops (and, or, xor): bitwise on WIDTH bits, upper half 0.
- Illegal opcode (6/7): result = 0, error = 1, carry_out = 0, overflow = 0. The conversion still runs, so bcd = 0.
- Display value, zero-extended to 2*WIDTH:
  - screen 0: opcode.
  - screen 1: a.
  - screen 2: b.
  - screen 3: result.
- Double dabble: each of the 2*WIDTH CONV cycles first adds 3 to every digit >= 5, then shifts left one bit.

## Timing
- Reset: state IDLE; in_ready = 1. out_valid, result, bcd, carry_out, overflow and error are all 0.
- EXEC length E: 1 cycle for non-mul. For mul, E = WIDTH cycles of shift-add (one partial product per cycle, LSB of b first).
- Latency: out_valid rises E + 2*WIDTH + 1 edges after the accepting edge. For WIDTH=4 that is 10 edges (non-mul) and 13 edges (mul).
- Backpressure: while out_valid && !out_ready, every output is held stable and in_ready stays 0.
- Throughput: in_ready returns 1 the cycle after the out handshake. There is no overlap of consecutive operations.
- rst asserted in any state: IDLE on the next edge, all outputs return to their reset values, and the in-flight operation is discarded.
- in_valid while !in_ready is ignored. No request is queued.

## Configuration
- ALU_COMB_MUL_EN defined: multiply is a single-cycle combinational array, E = 1 for every opcode.
- ALU_COMB_MUL_EN undefined: multiply uses the WIDTH-cycle shift-add datapath, with no multiplier array.
- Results, flags and all other timing are identical in both builds.

## Structure
- Package alu_pkg holds:
  - opcode enum (OP_ADD..OP_XOR, OP_ILL6, OP_ILL7);
  - screen enum;
  - FSM state enum;
  - function bcd_digits(bits) = ceil(bits*log10(2)), computed with integer arithmetic.
- Sub-module bcd_dabble_seq #(BITS, NDIG): start/done handshake with the parent. Performs the 2*WIDTH-cycle sequential conversion and is instantiated once.

## Test plan
- WIDTH=4, add a=9, b=8, carry_in=1, screen=3 -> result 2, carry_out 1, overflow 1, bcd 0x002, out_valid after 10 edges.
- mul a=15, b=15, screen=3, macro undefined -> result 225, bcd 0x225, out_valid after 13 edges. Same stimulus with the macro defined -> out_valid after 10 edges.
- sub a=3, b=5, carry_in=0, screen=3 -> result 14, carry_out 1, overflow 0, bcd 0x014. Same operands with screen=2 -> bcd 0x005.
- opcode 6, screen=3 -> error 1, result 0, bcd 0x000, carry_out 0, overflow 0.
- Hold out_ready=0 for 5 cycles after out_valid -> all outputs stable, in_ready 0. Handshake -> in_ready 1 on the next cycle.
- Assert rst for one cycle mid-CONV -> out_valid 0, in_ready 1, all outputs 0 on the next cycle. A fresh xor a=0xA, b=0x6 -> result 12, bcd 0x012.
